// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared decode constants, the shift operation enum and the payload
//            carried from stage to stage of shift_pipe_unit.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

   localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
   localparam logic [6:0] OPCODE_ITYPE = 7'b0010011;

   localparam logic [6:0] FUNC7_SHL = 7'b0000000;
   localparam logic [6:0] FUNC7_SRA = 7'b0100000;
   localparam logic [6:0] FUNC7_ROT = 7'b0110000;

   localparam logic [2:0] FUNC3_SL = 3'b001;
   localparam logic [2:0] FUNC3_SR = 3'b101;

   // The payload is sized for the widest configuration; narrower
   // configurations use the low bits and keep the rest at zero.
   localparam int MAX_XLEN = 64;
   localparam int MAX_SHW  = 6;
   localparam int MAX_TAGW = 16;

   typedef enum logic [2:0] {
      OP_SLL = 3'd0,
      OP_SRL = 3'd1,
      OP_SRA = 3'd2,
      OP_ROL = 3'd3,
      OP_ROR = 3'd4,
      OP_ILL = 3'd5
   } shift_op_e;

   typedef struct packed {
      logic [MAX_XLEN-1:0] data;   // operand, already bit-reversed for left ops
      logic                fill;   // bit shifted in from the top (non-rotate)
      logic                rot;    // wrap shifted-out bits back in
      logic                rev;    // bit-reverse again on exit
      logic [MAX_SHW-1:0]  shamt;
      logic [MAX_TAGW-1:0] tag;
      logic                ill;
   } shift_payload_t;

   // First shift level owned by stage k: ceil(shw*k/stages).
   function automatic int level_bound(input int shw, input int stages, input int k);
      return (shw * k + stages - 1) / stages;
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_stage
// Purpose  : One register stage of the shift pipe. Applies right-shift levels
//            LO..HI-1 (shift by 2^j when shamt[j] is set) to the incoming
//            payload and registers it behind a valid/ready handshake.
// Ports    : clk, rst_n, flush      - clock, async active-low reset, kill
//            in_valid/in_ready      - upstream handshake
//            in_pay                 - payload from previous stage / decode
//            out_valid/out_ready    - downstream handshake
//            out_pay                - registered payload
// Revision : 1.0 - initial release
// ============================================================================
module shift_stage
   import shift_pkg::*;
#(
   parameter int LO   = 0,
   parameter int HI   = 1,
   parameter int XLEN = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  shift_payload_t in_pay,
   output logic           out_valid,
   input  logic           out_ready,
   output shift_payload_t out_pay
);

   logic            valid_q;
   shift_payload_t  pay_q;
   shift_payload_t  pay_d;
   logic [XLEN-1:0] data_d;

   // A stage can take a new op when empty or when its current op leaves.
   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_pay   = pay_q;

   always_comb begin
      data_d = in_pay.data[XLEN-1:0];
      for (int j = LO; j < HI; j++) begin
         if (in_pay.shamt[j]) begin
            data_d = (data_d >> (1 << j)) |
                     (in_pay.rot  ? (data_d << (XLEN - (1 << j))) :
                      in_pay.fill ? ~({XLEN{1'b1}} >> (1 << j)) : '0);
         end
      end
      pay_d                = in_pay;
      pay_d.data[XLEN-1:0] = data_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (in_ready) begin
         valid_q <= in_valid;
      end
   end

   // Payload needs no reset: it is only observed while valid_q is set.
   always_ff @(posedge clk) begin
      if (in_ready && in_valid) begin
         pay_q <= pay_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/shift_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : shift_pipe_unit
// Purpose  : Pipelined shift/rotate execution unit. Decodes R/I-type shift
//            instructions, reverses left ops onto a single right-shift
//            datapath split over STAGES registers, and returns a tagged
//            result (or an illegal flag) to writeback.
// Ports    : clk, rst_n, flush           - clock, async active-low reset, kill
//            in_valid/in_ready           - request handshake
//            op1, op2, opcode, func3,
//            func7, imm, in_tag          - operands, instruction fields, tag
//            out_valid/out_ready         - result handshake
//            result, out_tag, illegal    - result, tag, illegal-op flag
// Revision : 1.0 - initial release
// ============================================================================
module shift_pipe_unit
   import shift_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int STAGES     = 2,
   parameter int ENABLE_ROT = 1,
   parameter int TAGW       = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [6:0]      opcode,
   input  logic [2:0]      func3,
   input  logic [6:0]      func7,
   input  logic [11:0]     imm,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [TAGW-1:0] out_tag,
   output logic            illegal
);

   localparam int SHW = $clog2(XLEN);

   function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      for (int i = 0; i < XLEN; i++) begin
         r[i] = v[XLEN-1-i];
      end
      return r;
   endfunction

   // ---------------------------------------------------------------- decode
   logic           is_r;
   logic           is_i;
   logic [6:0]     sel_i;
   logic [6:0]     sel;
   logic [SHW-1:0] shamt;
   shift_op_e      op;

   always_comb begin
      is_r  = (opcode == OPCODE_RTYPE);
      is_i  = (opcode == OPCODE_ITYPE);
      // On RV64 imm[5] is shamt bit 5, so only imm[11:6] selects; the
      // selector constants all have bit 0 clear, so pad with a zero.
      sel_i = (XLEN == 64) ? {imm[11:6], 1'b0} : imm[11:5];
      sel   = is_r ? func7 : sel_i;
      shamt = is_r ? op2[SHW-1:0] : imm[SHW-1:0];

      op = OP_ILL;
      if (is_r || is_i) begin
         if (func3 == FUNC3_SL && sel == FUNC7_SHL) begin
            op = OP_SLL;
         end else if (func3 == FUNC3_SR && sel == FUNC7_SHL) begin
            op = OP_SRL;
         end else if (func3 == FUNC3_SR && sel == FUNC7_SRA) begin
            op = OP_SRA;
         end else if (ENABLE_ROT != 0 && sel == FUNC7_ROT) begin
            // There is no ROLI; only the R-type form rotates left.
            if (func3 == FUNC3_SR) begin
               op = OP_ROR;
            end else if (func3 == FUNC3_SL && is_r) begin
               op = OP_ROL;
            end
         end
      end
   end

   // --------------------------------------------------------- entry payload
   shift_payload_t pay_in;
   logic           rev_in;

   always_comb begin
      rev_in                = (op == OP_SLL) || (op == OP_ROL);
      pay_in                = '0;
      pay_in.data[XLEN-1:0] = rev_in ? bit_rev(op1) : op1;
      pay_in.fill           = (op == OP_SRA) && op1[XLEN-1];
      pay_in.rot            = (op == OP_ROL) || (op == OP_ROR);
      pay_in.rev            = rev_in;
      pay_in.shamt[SHW-1:0] = shamt;
      pay_in.tag[TAGW-1:0]  = in_tag;
      pay_in.ill            = (op == OP_ILL);
   end

   // ----------------------------------------------------------- stage chain
   shift_payload_t  pay [STAGES+1];
   logic [STAGES:0] vld;
   logic [STAGES:0] rdy;

   assign pay[0]      = pay_in;
   assign vld[0]      = in_valid;
   assign rdy[STAGES] = out_ready;
   assign in_ready    = !flush && rdy[0];

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         shift_stage #(
            .LO   (level_bound(SHW, STAGES, k)),
            .HI   (level_bound(SHW, STAGES, k + 1)),
            .XLEN (XLEN)
         ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (vld[k]),
            .in_ready  (rdy[k]),
            .in_pay    (pay[k]),
            .out_valid (vld[k+1]),
            .out_ready (rdy[k+1]),
            .out_pay   (pay[k+1])
         );
      end
   endgenerate

   // ------------------------------------------------------------------ exit
   shift_payload_t  last;
   logic [XLEN-1:0] last_data;

   assign last      = pay[STAGES];
   assign last_data = last.rev ? bit_rev(last.data[XLEN-1:0]) : last.data[XLEN-1:0];

   // Outputs are forced to zero when nothing is valid, so the unreset data
   // registers never leak out.
   assign out_valid = vld[STAGES];
   assign result    = (out_valid && !last.ill) ? last_data : '0;
   assign out_tag   = out_valid ? last.tag[TAGW-1:0] : '0;
   assign illegal   = out_valid && last.ill;

   // Padding bits of the shared payload and upper op2 bits are intentionally
   // not consumed.
   logic unused_ok;
   assign unused_ok = &{1'b0, last, op2};

endmodule
`default_nettype wire
